// File: rtl/serial_pkg.sv
// Shared types and constants for the serial message receiver.
package serial_pkg;
  localparam int BYTE_W          = 8;
  localparam int CLK_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte deframer: synchronizes rx, finds the start bit and samples at mid-bit.
module uart_rx_byte
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              active
);
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(BYTE_W);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTE_W - 1);

  rx_state_e         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [BYTE_W-1:0] shreg, shreg_d;
  logic              rx_s1, rx_s2, rx_q;
  logic              fall, tick;

  // rx_q delays the synchronized line one more cycle for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  assign fall = rx_q & ~rx_s2;
  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shreg <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx;
    shreg_d    = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_d = START;
        cnt_d   = HALF;
      end
      START: if (tick) begin
        if (!rx_s2) begin
          state_d = DATA;
          cnt_d   = FULL;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt - 1'b1;
      end
      DATA: if (tick) begin
        shreg_d = {rx_s2, shreg[BYTE_W-1:1]};
        cnt_d   = FULL;
        if (idx == LAST) state_d = STOP;
        else             idx_d   = idx + 1'b1;
      end else begin
        cnt_d = cnt - 1'b1;
      end
      STOP: if (tick) begin
        // remainder of the stop bit is spent in IDLE, so an early next start edge is caught there
        byte_valid = rx_s2;
        frame_err  = ~rx_s2;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte = shreg;
  assign active  = (state != IDLE);
endmodule

// File: rtl/serial_msg_rx.sv
// Assembles MSG_LEN UART bytes into one message, first byte in the MSB.
// Optional idle timeout on partial messages: define SERIAL_RX_TIMEOUT_EN.
module serial_msg_rx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT  = CLK_PER_BIT_DEF,
  parameter int MSG_LEN      = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [BYTE_W*MSG_LEN-1:0] data,
  output logic                      valid,
  output logic                      busy,
  output logic                      err
);
  localparam int MSG_W  = BYTE_W * MSG_LEN;
  localparam int BCNT_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [BCNT_W-1:0] BLAST = BCNT_W'(MSG_LEN - 1);

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_valid, frame_err, active;
  logic [MSG_W-1:0]  asm_q, asm_nx;
  logic [BCNT_W-1:0] bcnt;
  logic              timeout;

  uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .active     (active)
  );

  assign asm_nx = (asm_q << BYTE_W) | MSG_W'(rx_byte);

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int IDLE_LIM = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int IDLE_W   = $clog2(IDLE_LIM);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_LIM - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // any byte in flight (including its start edge) restarts the idle window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         idle_cnt <= '0;
    else if (active || bcnt == '0)    idle_cnt <= '0;
    else if (idle_cnt == IDLE_END)    idle_cnt <= '0;
    else                              idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = !active && (bcnt != '0) && (idle_cnt == IDLE_END);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q <= '0;
      bcnt  <= '0;
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= frame_err;
      if (frame_err || timeout) begin
        asm_q <= '0;
        bcnt  <= '0;
      end else if (byte_valid) begin
        if (bcnt == BLAST) begin
          data  <= asm_nx;
          valid <= 1'b1;
          asm_q <= '0;
          bcnt  <= '0;
        end else begin
          asm_q <= asm_nx;
          bcnt  <= bcnt + 1'b1;
        end
      end
    end
  end

  assign busy = active | (bcnt != '0);
endmodule

// File: tb/tb_serial_msg_rx.sv
// Directed + random bench for serial_msg_rx with a byte-queue reference model.
module tb_serial_msg_rx;
  localparam int CPB = 16;
  localparam int ML  = 4;
  localparam int TB  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [31:0] data;
  logic        valid, busy, err;
  logic [7:0]  data1;
  logic        valid1, busy1, err1;

  always #5 clk = ~clk;

  serial_msg_rx #(.CLK_PER_BIT(CPB), .MSG_LEN(ML), .TIMEOUT_BITS(TB)) u_dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .busy(busy), .err(err));

  serial_msg_rx #(.CLK_PER_BIT(CPB), .MSG_LEN(1), .TIMEOUT_BITS(TB)) u_one (
    .clk(clk), .rst(rst), .rx(rx), .data(data1), .valid(valid1), .busy(busy1), .err(err1));

  int n_chk = 0, n_fail = 0;
  int vcnt = 0, ecnt = 0, v1cnt = 0, tbad = 0;
  logic bv_prev = 1'b0;

  // pulse monitor; the single-byte instance's valid must trail its stop sample by one cycle
  always @(negedge clk) begin
    if (valid)  vcnt++;
    if (err)    ecnt++;
    if (valid1) v1cnt++;
    if (valid1 !== bv_prev) tbad++;
    bv_prev = u_one.u_rx.byte_valid;
  end

  // reference model
  logic [7:0]  q[$];
  logic [31:0] exp_data = '0;
  logic [7:0]  exp1 = '0;
  int          exp_v = 0, exp_e = 0, exp_v1 = 0;

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      q.delete();
      exp_e++;
    end else begin
      q.push_back(b);
      exp_v1++;
      exp1 = b;
      if (q.size() == ML) begin
        exp_data = '0;
        foreach (q[i]) exp_data = {exp_data[23:0], q[i]};
        exp_v++;
        q.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_vcnt"}, 64'(vcnt), 64'(exp_v));
    chk({tag, "_ecnt"}, 64'(ecnt), 64'(exp_e));
    chk({tag, "_data"}, 64'(data), 64'(exp_data));
    chk({tag, "_busy"}, 64'(busy), 64'(q.size() != 0));
    chk({tag, "_v1"},   64'(v1cnt), 64'(exp_v1));
    chk({tag, "_d1"},   64'(data1), 64'(exp1));
  endtask

  task automatic send(input logic [7:0] b, input bit good);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    model_byte(b, good);
  endtask

  task automatic idle_bits(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
`ifdef SERIAL_RX_TIMEOUT_EN
    if (bits > TB) q.delete();
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msg [4];
    logic [7:0] b;
    bit seen;

    // reset state
    repeat (5) @(negedge clk);
    chk("rst_data",  64'(data),  64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_err",   64'(err),   64'h0);
    chk("rst_busy",  64'(busy),  64'h0);
    rst = 1'b1;
    idle_bits(2);

    // back-to-back message
    msg = '{8'h7F, 8'h1F, 8'h07, 8'h01};
    foreach (msg[i]) send(msg[i], 1'b1);
    idle_bits(1);
    check_state("b2b");
    chk("b2b_const", 64'(data), 64'h7F1F0701);

    // short low glitch while idle
    seen = 1'b0;
    rx = 1'b0;
    repeat (3) begin @(negedge clk); if (busy) seen = 1'b1; end
    rx = 1'b1;
    for (int i = 0; i < CPB / 2 + 3; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("glitch_seen", 64'(seen), 64'h1);
    chk("glitch_busy_low", 64'(busy), 64'h0);
    idle_bits(1);
    check_state("glitch");

    // framing error on byte 2, then a clean message
    send(8'hC3, 1'b1);
    send(8'h5E, 1'b0);
    idle_bits(1);
    check_state("ferr");
    msg = '{8'h0F, 8'h17, 8'h33, 8'h71};
    foreach (msg[i]) send(msg[i], 1'b1);
    idle_bits(1);
    check_state("after_ferr");
    chk("after_ferr_const", 64'(data), 64'h0F173371);

    // long idle gap inside a message
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    idle_bits(30);
    msg = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (msg[i]) send(msg[i], 1'b1);
    idle_bits(1);
    check_state("gap");
`ifdef SERIAL_RX_TIMEOUT_EN
    chk("gap_const", 64'(data), 64'h11223344);
`else
    chk("gap_const", 64'(data), 64'hAABB1122);
`endif

    // reset in the middle of byte 3
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    b = 8'h56;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[3];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_data",  64'(data),  64'h0);
    chk("mrst_valid", 64'(valid), 64'h0);
    chk("mrst_err",   64'(err),   64'h0);
    chk("mrst_busy",  64'(busy),  64'h0);
    chk("mrst_data1", 64'(data1), 64'h0);
    q.delete();
    exp_data = '0;
    exp1 = '0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_bits(2);
    msg = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (msg[i]) send(msg[i], 1'b1);
    idle_bits(1);
    check_state("post_rst");
    chk("post_rst_const", 64'(data), 64'hDEADBEEF);

    // single-byte message build
    send(8'h5A, 1'b1);
    idle_bits(1);
    chk("one_data", 64'(data1), 64'h5A);
    chk("one_timing", 64'(tbad), 64'h0);

    // random bytes with occasional bad stop bits and short gaps
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      send(b, $urandom_range(0, 9) != 0);
      idle_bits($urandom_range(0, 2));
      if (n % 4 == 3) check_state("rand");
    end
    idle_bits(1);
    check_state("rand_end");
    chk("valid_timing", 64'(tbad), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
